// File: rtl/vfd_piso_shiftreg_pkg.sv
// Shared types and constants for the parallel-in / serial-out transmitter.
package vfd_piso_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  localparam int c_width_default = 5;

  // Bit counter only needs to reach c_width-1, so $clog2 of the width suffices.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/vfd_piso_shiftreg_if.sv
// Word load handshake plus bit-serial output stream for vfd_piso_shiftreg.
interface vfd_piso_shiftreg_if
  import vfd_piso_pkg::*;
#(
  parameter int c_width = c_width_default
);

  logic [c_width-1:0] i_data;
  logic               i_valid;
  logic               o_ready;
  logic               o_serial;
  logic               o_valid;
  logic               i_ready;
  logic               o_last;
  logic               o_busy;

  modport master (
    output i_data, i_valid, i_ready,
    input  o_ready, o_serial, o_valid, o_last, o_busy
  );

  modport slave (
    input  i_data, i_valid, i_ready,
    output o_ready, o_serial, o_valid, o_last, o_busy
  );

endinterface

// File: rtl/vfd_piso_shiftreg_counter.sv
// Loadable down-counter with hold enable and zero flag; tracks bits left in a word.
module vfd_piso_counter #(
  parameter int c_cnt_w = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [c_cnt_w-1:0] load_val,
  input  logic               dec_en,
  output logic [c_cnt_w-1:0] count,
  output logic               zero
);

  logic [c_cnt_w-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec_en) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign count = cnt_q;
  assign zero  = (cnt_q == '0);

endmodule

// File: rtl/vfd_piso_shiftreg.sv
// Parallel-in, serial-out shift register: one word in via valid/ready, one bit per transfer out.
//
// state   | meaning
// S_IDLE  | no word held, o_ready=1, o_valid=0
// S_SHIFT | word in flight, o_valid=1, o_serial shows current bit
module vfd_piso_shiftreg
  import vfd_piso_pkg::*;
#(
  parameter int c_width     = c_width_default,
  parameter bit p_lsb_first = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  vfd_piso_shiftreg_if.slave bus
);

  localparam int                 c_cnt_w    = cnt_width(c_width);
  localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(c_width - 1);

  state_e             state_q;
  state_e             state_d;
  logic [c_width-1:0] shreg_q;
  logic [c_cnt_w-1:0] cnt;
  logic               cnt_zero;
  logic               valid_c;
  logic               busy_c;
  logic               last_c;
  logic               ready_c;
  logic               load;
  logic               xfer;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (load) state_d = S_SHIFT;
      S_SHIFT: if (xfer && last_c && !load) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // o_ready reaches back to i_ready only on the last bit, enabling gapless reload.
  always_comb begin
    valid_c = (state_q == S_SHIFT);
    busy_c  = (state_q == S_SHIFT);
    last_c  = (state_q == S_SHIFT) && cnt_zero;
    ready_c = (state_q == S_IDLE) || (last_c && bus.i_ready);
  end

  assign load = bus.i_valid && ready_c;
  assign xfer = valid_c && bus.i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
    end else if (load) begin
      shreg_q <= bus.i_data;
    end else if (xfer) begin
      shreg_q <= p_lsb_first ? {1'b0, shreg_q[c_width-1:1]}
                             : {shreg_q[c_width-2:0], 1'b0};
    end
  end

  // Counter must not decrement past zero; a finished word either reloads or idles.
  vfd_piso_counter #(
    .c_cnt_w (c_cnt_w)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (c_cnt_load),
    .dec_en   (xfer && !cnt_zero),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  // After a full word the register has shifted to all zeros, so o_serial is 0 in IDLE.
  assign bus.o_serial = p_lsb_first ? shreg_q[0] : shreg_q[c_width-1];
  assign bus.o_valid  = valid_c;
  assign bus.o_busy   = busy_c;
  assign bus.o_last   = last_c;
  assign bus.o_ready  = ready_c;

endmodule

// File: tb/tb_vfd_piso_shiftreg.sv
// Directed bench for vfd_piso_shiftreg: LSB-first and MSB-first instances side by side.
module tb_vfd_piso_shiftreg;

  logic clk_tb;
  logic rst_tb;
  int   total;
  int   bad;

  vfd_piso_shiftreg_if #(.c_width(5)) bus_lsb ();
  vfd_piso_shiftreg_if #(.c_width(5)) bus_msb ();

  vfd_piso_shiftreg #(.c_width(5), .p_lsb_first(1'b1)) u_dut_lsb (
    .clk (clk_tb),
    .rst (rst_tb),
    .bus (bus_lsb)
  );

  vfd_piso_shiftreg #(.c_width(5), .p_lsb_first(1'b0)) u_dut_msb (
    .clk (clk_tb),
    .rst (rst_tb),
    .bus (bus_msb)
  );

  initial clk_tb = 1'b0;
  always #5 clk_tb = ~clk_tb;

  task automatic tick;
    @(posedge clk_tb);
    #1;
  endtask

  task automatic test_reset;
    rst_tb = 1'b1;
    tick();
    tick();
    total++; if (bus_lsb.o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus_lsb.o_valid); end
    total++; if (bus_lsb.o_serial !== 1'b0) begin bad++; $display("FAIL reset_serial got=%b want=0", bus_lsb.o_serial); end
    total++; if (bus_lsb.o_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b want=0", bus_lsb.o_last); end
    total++; if (bus_lsb.o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus_lsb.o_busy); end
    total++; if (bus_lsb.o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus_lsb.o_ready); end
    total++; if (bus_msb.o_valid !== 1'b0 || bus_msb.o_ready !== 1'b1) begin
      bad++; $display("FAIL reset_msb valid=%b ready=%b want valid=0 ready=1", bus_msb.o_valid, bus_msb.o_ready);
    end
    rst_tb = 1'b0;
    tick();
  endtask

  task automatic test_basic;
    bit exp_ser[5] = '{0, 1, 1, 0, 1};
    bus_lsb.i_data  = 5'b10110;
    bus_lsb.i_valid = 1'b1;
    bus_lsb.i_ready = 1'b1;
    tick();
    bus_lsb.i_valid = 1'b0;
    bus_lsb.i_data  = 5'b00000;
    for (int i = 0; i < 5; i++) begin
      total++; if (bus_lsb.o_valid !== 1'b1) begin bad++; $display("FAIL basic_valid c%0d got=%b want=1", i+1, bus_lsb.o_valid); end
      total++; if (bus_lsb.o_serial !== exp_ser[i]) begin bad++; $display("FAIL basic_serial c%0d got=%b want=%b", i+1, bus_lsb.o_serial, exp_ser[i]); end
      total++; if (bus_lsb.o_last !== (i == 4)) begin bad++; $display("FAIL basic_last c%0d got=%b want=%b", i+1, bus_lsb.o_last, (i == 4)); end
      total++; if (bus_lsb.o_ready !== (i == 4)) begin bad++; $display("FAIL basic_ready c%0d got=%b want=%b", i+1, bus_lsb.o_ready, (i == 4)); end
      total++; if (bus_lsb.o_busy !== 1'b1) begin bad++; $display("FAIL basic_busy c%0d got=%b want=1", i+1, bus_lsb.o_busy); end
      tick();
    end
    total++; if (bus_lsb.o_valid !== 1'b0 || bus_lsb.o_ready !== 1'b1 || bus_lsb.o_busy !== 1'b0) begin
      bad++; $display("FAIL basic_idle valid=%b ready=%b busy=%b want 0 1 0", bus_lsb.o_valid, bus_lsb.o_ready, bus_lsb.o_busy);
    end
  endtask

  task automatic test_stall;
    bit rdy[8]     = '{1, 0, 0, 0, 1, 1, 1, 1};
    bit exp_ser[8] = '{0, 1, 1, 1, 1, 1, 0, 1};
    bit exp_lst[8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    bus_lsb.i_data  = 5'b10110;
    bus_lsb.i_valid = 1'b1;
    bus_lsb.i_ready = 1'b1;
    tick();
    bus_lsb.i_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus_lsb.i_ready = rdy[i];
      #1;
      total++; if (bus_lsb.o_valid !== 1'b1) begin bad++; $display("FAIL stall_valid c%0d got=%b want=1", i+1, bus_lsb.o_valid); end
      total++; if (bus_lsb.o_serial !== exp_ser[i]) begin bad++; $display("FAIL stall_serial c%0d got=%b want=%b", i+1, bus_lsb.o_serial, exp_ser[i]); end
      total++; if (bus_lsb.o_last !== exp_lst[i]) begin bad++; $display("FAIL stall_last c%0d got=%b want=%b", i+1, bus_lsb.o_last, exp_lst[i]); end
      total++; if (bus_lsb.o_ready !== (exp_lst[i] & rdy[i])) begin bad++; $display("FAIL stall_ready c%0d got=%b want=%b", i+1, bus_lsb.o_ready, exp_lst[i] & rdy[i]); end
      tick();
    end
    bus_lsb.i_ready = 1'b1;
    #1;
    total++; if (bus_lsb.o_valid !== 1'b0) begin bad++; $display("FAIL stall_idle got=%b want=0", bus_lsb.o_valid); end
  endtask

  task automatic test_back_to_back;
    bit exp_ser[10] = '{1, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    bus_lsb.i_data  = 5'b00001;
    bus_lsb.i_valid = 1'b1;
    bus_lsb.i_ready = 1'b1;
    tick();
    bus_lsb.i_data = 5'b11110;
    for (int i = 0; i < 10; i++) begin
      bus_lsb.i_valid = (i <= 4);
      #1;
      total++; if (bus_lsb.o_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid c%0d got=%b want=1", i+1, bus_lsb.o_valid); end
      total++; if (bus_lsb.o_serial !== exp_ser[i]) begin bad++; $display("FAIL b2b_serial c%0d got=%b want=%b", i+1, bus_lsb.o_serial, exp_ser[i]); end
      total++; if (bus_lsb.o_last !== (i == 4 || i == 9)) begin bad++; $display("FAIL b2b_last c%0d got=%b want=%b", i+1, bus_lsb.o_last, (i == 4 || i == 9)); end
      tick();
    end
    bus_lsb.i_valid = 1'b0;
    #1;
    total++; if (bus_lsb.o_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b want=0", bus_lsb.o_valid); end
  endtask

  task automatic test_reset_mid_word;
    bit exp_ser[5] = '{0, 0, 1, 0, 0};
    bus_lsb.i_data  = 5'b11111;
    bus_lsb.i_valid = 1'b1;
    bus_lsb.i_ready = 1'b1;
    tick();
    bus_lsb.i_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++; if (bus_lsb.o_serial !== 1'b1) begin bad++; $display("FAIL rstmid_pre c%0d got=%b want=1", i+1, bus_lsb.o_serial); end
      tick();
    end
    rst_tb = 1'b1;
    tick();
    rst_tb = 1'b0;
    total++; if (bus_lsb.o_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b want=0", bus_lsb.o_valid); end
    total++; if (bus_lsb.o_serial !== 1'b0) begin bad++; $display("FAIL rstmid_serial got=%b want=0", bus_lsb.o_serial); end
    total++; if (bus_lsb.o_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b want=1", bus_lsb.o_ready); end
    total++; if (bus_lsb.o_busy !== 1'b0 || bus_lsb.o_last !== 1'b0) begin
      bad++; $display("FAIL rstmid_busy_last busy=%b last=%b want 0 0", bus_lsb.o_busy, bus_lsb.o_last);
    end
    bus_lsb.i_data  = 5'b00100;
    bus_lsb.i_valid = 1'b1;
    tick();
    bus_lsb.i_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++; if (bus_lsb.o_valid !== 1'b1 || bus_lsb.o_serial !== exp_ser[i]) begin
        bad++; $display("FAIL rstmid_word c%0d valid=%b serial=%b want 1 %b", i+1, bus_lsb.o_valid, bus_lsb.o_serial, exp_ser[i]);
      end
      total++; if (bus_lsb.o_last !== (i == 4)) begin bad++; $display("FAIL rstmid_last c%0d got=%b want=%b", i+1, bus_lsb.o_last, (i == 4)); end
      tick();
    end
    total++; if (bus_lsb.o_valid !== 1'b0) begin bad++; $display("FAIL rstmid_idle got=%b want=0", bus_lsb.o_valid); end
  endtask

  task automatic test_msb_first;
    bit exp_ser[5] = '{1, 0, 1, 1, 0};
    bus_msb.i_data  = 5'b10110;
    bus_msb.i_valid = 1'b1;
    bus_msb.i_ready = 1'b1;
    tick();
    bus_msb.i_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++; if (bus_msb.o_valid !== 1'b1 || bus_msb.o_serial !== exp_ser[i]) begin
        bad++; $display("FAIL msb_serial c%0d valid=%b serial=%b want 1 %b", i+1, bus_msb.o_valid, bus_msb.o_serial, exp_ser[i]);
      end
      total++; if (bus_msb.o_last !== (i == 4)) begin bad++; $display("FAIL msb_last c%0d got=%b want=%b", i+1, bus_msb.o_last, (i == 4)); end
      tick();
    end
    total++; if (bus_msb.o_valid !== 1'b0 || bus_msb.o_serial !== 1'b0) begin
      bad++; $display("FAIL msb_idle valid=%b serial=%b want 0 0", bus_msb.o_valid, bus_msb.o_serial);
    end
  endtask

  task automatic test_ignore_mid_word;
    bit exp_ser[5] = '{0, 1, 1, 0, 1};
    bus_lsb.i_data  = 5'b10110;
    bus_lsb.i_valid = 1'b1;
    bus_lsb.i_ready = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      bus_lsb.i_valid = (i == 1);
      bus_lsb.i_data  = (i == 1) ? 5'b01001 : 5'b00000;
      #1;
      total++; if (bus_lsb.o_serial !== exp_ser[i]) begin bad++; $display("FAIL ignore_serial c%0d got=%b want=%b", i+1, bus_lsb.o_serial, exp_ser[i]); end
      total++; if (bus_lsb.o_ready !== (i == 4)) begin bad++; $display("FAIL ignore_ready c%0d got=%b want=%b", i+1, bus_lsb.o_ready, (i == 4)); end
      tick();
    end
    total++; if (bus_lsb.o_valid !== 1'b0 || bus_lsb.o_ready !== 1'b1) begin
      bad++; $display("FAIL ignore_idle valid=%b ready=%b want 0 1", bus_lsb.o_valid, bus_lsb.o_ready);
    end
  endtask

  initial begin
    total           = 0;
    bad             = 0;
    rst_tb          = 1'b1;
    bus_lsb.i_data  = '0;
    bus_lsb.i_valid = 1'b0;
    bus_lsb.i_ready = 1'b1;
    bus_msb.i_data  = '0;
    bus_msb.i_valid = 1'b0;
    bus_msb.i_ready = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_reset_mid_word();
    test_msb_first();
    test_ignore_mid_word();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
